// File: rtl/gate_sweep_pkg.sv
// Shared types and constants for the two-input gate sweep controller.
// State encodings, vector count and reference truth tables (bit i = y for {a,b}=i).
package gate_sweep_pkg;

    localparam int N_VEC = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_CHECK  = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] TT_NOR  = 4'b0001;
    localparam logic [3:0] TT_AND  = 4'b1000;
    localparam logic [3:0] TT_OR   = 4'b1110;
    localparam logic [3:0] TT_NAND = 4'b0111;
    localparam logic [3:0] TT_XOR  = 4'b0110;

    typedef struct packed {
        logic       pass;
        logic [2:0] err_count;
        logic [3:0] fail_vec;
    } sweep_result_t;

endpackage

// File: rtl/settle_timer.sv
// Loadable down-counter that times how long each vector is held before sampling.
// Loading SETTLE-1 makes the zero flag rise after exactly SETTLE cycles in the settle state.
module settle_timer #(
    parameter int SETTLE = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic en,
    output logic zero
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= 8'd0;
        end else if (load) begin
            cnt <= 8'(SETTLE - 1);
        end else if (en && !zero) begin
            cnt <= cnt - 8'd1;
        end
    end

    assign zero = (cnt == 8'd0);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Drives all four {a,b} vectors into a two-input gate, holds each for SETTLE cycles,
// then compares y against a latched truth table and reports per-vector mismatches.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] truth_table,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    localparam logic [1:0] S_IDLE   = ST_IDLE;
    localparam logic [1:0] S_SETTLE = ST_SETTLE;
    localparam logic [1:0] S_CHECK  = ST_CHECK;
    localparam logic [1:0] S_DONE   = ST_DONE;
    localparam logic [1:0] LAST_VEC = 2'(N_VEC - 1);

    logic [1:0]    state, state_nx;
    logic [1:0]    vec;
    logic [3:0]    latched_tt;
    sweep_result_t res;
    logic          tmr_load, tmr_en, tmr_zero;
    logic          mismatch;
    logic [2:0]    err_nx;

    settle_timer #(.SETTLE(SETTLE)) u_settle (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .en    (tmr_en),
        .zero  (tmr_zero)
    );

    // 4-state compare so an undriven or X gate output is caught as a failure
    assign mismatch = (y !== latched_tt[vec]);
    assign err_nx   = res.err_count + {2'b00, mismatch};

    always_comb begin
        state_nx = state;
        tmr_load = 1'b0;
        tmr_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nx = S_SETTLE;
                    tmr_load = 1'b1;
                end
            end
            S_SETTLE: begin
                tmr_en = 1'b1;
                if (tmr_zero) state_nx = S_CHECK;
            end
            S_CHECK: begin
                if (vec == LAST_VEC) begin
                    state_nx = S_DONE;
                end else begin
                    state_nx = S_SETTLE;
                    tmr_load = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            vec        <= 2'd0;
            latched_tt <= 4'd0;
            res        <= '0;
            a          <= 1'b0;
            b          <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state <= state_nx;
            busy  <= (state_nx != S_IDLE);
            done  <= (state_nx == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start) begin
                        latched_tt <= truth_table;
                        res        <= '0;
                        vec        <= 2'd0;
                        {a, b}     <= 2'b00;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        res.err_count <= err_nx;
                        res.fail_vec[vec] <= 1'b1;
                    end
                    if (vec == LAST_VEC) begin
                        // pass is resolved on the DONE entry edge so it is valid alongside done
                        res.pass <= (err_nx == 3'd0);
                    end else begin
                        vec    <= vec + 2'd1;
                        {a, b} <= vec + 2'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign pass      = res.pass;
    assign err_count = res.err_count;
    assign fail_vec  = res.fail_vec;

endmodule
